hilo_div_ctrl: RTL and testbench
================================

Name: hilo_div_ctrl

Overview:
Downstream of the sequential signed 64/32 divider; owns the HI/LO register pair of the lab CPU.
- Accepts DIV/MTHI/MTLO/CLR requests from decode.
- Sequences one divider operation per DIV, then commits quotient to LO and remainder to HI.
- Reports divide-by-zero, overflow and timeout; drives busy for pipeline stall.

Parameters:
WIDTH, 32, data width of rs/rt/HI/LO (divider dividend is 2*WIDTH)
TIMEOUT, 40, max WAIT cycles before abort (must exceed divider iteration count + 2)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  high only in IDLE
req_op  in  2  00 DIV, 01 MTHI, 10 MTLO, 11 CLR (HI=LO=0)
req_rs  in  WIDTH  dividend / move source
req_rt  in  WIDTH  divisor
busy  out  1  state != IDLE
hi  out  WIDTH  HI register (remainder)
lo  out  WIDTH  LO register (quotient)
div_start  out  1  one-cycle start pulse to divider
div_a  out  2*WIDTH  rs sign-extended, held stable ISSUE..WAIT
div_b  out  WIDTH  rt, held stable ISSUE..WAIT
div_q  in  WIDTH  divider quotient
div_r  in  WIDTH  divider remainder
div_dz  in  1  divider zero-divisor flag
div_do  in  1  divider overflow flag
div_done  in  1  result valid, sampled only in WAIT
err_code  out  2  00 none, 01 zero, 10 overflow, 11 timeout; sticky
err_clr  in  1  clears err_code to 00

Behaviour:
- Reset (async, rst_n=0): state IDLE; hi, lo, div_a, div_b, err_code = 0; div_start=0; wait counter=0. Reset mid-operation aborts with no commit; divider output ignored until the next DIV.
- Handshake: transfer on clk edge with req_valid & req_ready. When req_ready=0, the request is not taken; upstream holds it.
- FSM IDLE -> ISSUE -> WAIT -> IDLE:
  - IDLE: MTHI/MTLO/CLR write hi/lo at the accept edge and stay in IDLE (1-cycle op, back-to-back allowed). DIV latches div_a={{WIDTH{rs[WIDTH-1]}},rs} and div_b=rt, then goes to ISSUE.
  - ISSUE: div_start=1 for exactly this cycle; counter cleared; go to WAIT.
  - WAIT: counter increments each cycle. div_done=1 means commit and go to IDLE:
    - div_dz: err_code<=01, hi/lo unchanged.
    - else div_do: err_code<=10, hi/lo unchanged.
    - else lo<=div_q, hi<=div_r.
  - Timeout: counter==TIMEOUT-1 without done gives err_code<=11 and IDLE, no commit.
- Latency: DIV accepted at edge 0; start pulse is cycle 1; hi/lo valid the cycle after the edge on which div_done is sampled. req_ready returns the same cycle.
- Simultaneous events:
  - div_done and timeout in the same cycle: done wins.
  - err_clr and new error on the same edge: new error wins.
  - err_clr while busy: clears immediately.
  - div_done outside WAIT: ignored.
- err_code is sticky: the last error overwrites; successful ops do not clear it.
- Arithmetic is signed two's-complement only; no unsigned divide.

Optional Feature:
DIV_ZERO_TRAP_EN:
- Defined: adds output port dz_trap (1 bit). It pulses high for exactly one cycle on the commit edge when div_dz=1, in addition to err_code=01.
- Undefined: port absent; divide-by-zero is reported only via err_code.

Decomposition:
- Package hilo_pkg:
  - op encodings (OP_DIV, OP_MTHI, OP_MTLO, OP_CLR)
  - FSM state encodings (S_IDLE, S_ISSUE, S_WAIT)
  - error codes (ERR_NONE, ERR_DZ, ERR_DO, ERR_TO)
- Sub-module hilo_regs: HI/LO pair with async reset, separate write enables and a clear. The FSM and counter stay in the top level.

Test Plan:
- DIV rs=-7 (0xFFFFFFF9), rt=2, divider returns q=0xFFFFFFFD, r=0xFFFFFFFF after 34 cycles -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, err_code=00, div_a=0xFFFFFFFF_FFFFFFF9, one start pulse.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles -> hi/lo updated one cycle each, busy never asserted.
- DIV rt=0, divider returns div_done with div_dz=1 -> err_code=01, hi/lo unchanged. With DIV_ZERO_TRAP_EN, dz_trap high for 1 cycle. err_clr next cycle -> 00.
- DIV with div_done withheld -> after 40 WAIT cycles err_code=11, state IDLE. A late div_done is then ignored and hi/lo unchanged.
- rst_n low in WAIT cycle 10 -> hi=lo=0, err=00, req_ready=1 immediately. A subsequent DIV 100/7 gives lo=14, hi=2.
- req_valid held while busy with MTLO 0x1 -> not accepted until IDLE, then lo=1.

Source files
------------

// File: rtl/hilo_pkg.sv
// hilo_pkg: shared encodings for the HI/LO divide controller.
package hilo_pkg;
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_MTHI = 2'b01;
  localparam logic [1:0] OP_MTLO = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_DZ   = 2'b01;
  localparam logic [1:0] ERR_DO   = 2'b10;
  localparam logic [1:0] ERR_TO   = 2'b11;
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10
  } state_e;
endpackage

// File: rtl/hilo_regs.sv
// hilo_regs: HI/LO register pair with per-register write enables and a joint clear.
module hilo_regs #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             hi_we_i,
  input  logic [WIDTH-1:0] hi_wd_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] lo_wd_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  always_comb begin
    hi_d = clr_i ? '0 : hi_we_i ? hi_wd_i : hi_q;
    lo_d = clr_i ? '0 : lo_we_i ? lo_wd_i : lo_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
  assign hi_o = hi_q;
  assign lo_o = lo_q;
endmodule

// File: rtl/hilo_div_ctrl.sv
// hilo_div_ctrl: sequences the external signed divider and owns HI/LO.
// Define DIV_ZERO_TRAP_EN to add the dz_trap one-cycle divide-by-zero pulse output.
module hilo_div_ctrl
  import hilo_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 40
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [WIDTH-1:0]   req_rs,
  input  logic [WIDTH-1:0]   req_rt,
  output logic               busy,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               div_start,
  output logic [2*WIDTH-1:0] div_a,
  output logic [WIDTH-1:0]   div_b,
  input  logic [WIDTH-1:0]   div_q,
  input  logic [WIDTH-1:0]   div_r,
  input  logic               div_dz,
  input  logic               div_do,
  input  logic               div_done,
  output logic [1:0]         err_code,
  input  logic               err_clr
`ifdef DIV_ZERO_TRAP_EN
  ,
  output logic               dz_trap
`endif
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] div_a_q, div_a_d;
  logic [WIDTH-1:0] div_b_q, div_b_d;
  logic [1:0] err_q, err_d;
  logic accept, take_div, done_w, tmo, commit_ok;
  logic hi_we, lo_we, hl_clr;
  logic [WIDTH-1:0] hi_wd, lo_wd;
  assign accept    = req_valid & req_ready;
  assign take_div  = accept & (req_op == OP_DIV);
  assign done_w    = (state_q == S_WAIT) & div_done;
  // done in the final WAIT cycle still commits; timeout only fires without it
  assign tmo       = (state_q == S_WAIT) & ~div_done & (cnt_q == CW'(TIMEOUT - 1));
  assign commit_ok = done_w & ~div_dz & ~div_do;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  state_d = take_div ? S_ISSUE : S_IDLE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  state_d = (div_done || tmo) ? S_IDLE : S_WAIT;
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    req_ready = state_q == S_IDLE;
    busy      = state_q != S_IDLE;
    div_start = state_q == S_ISSUE;
    hl_clr    = accept & (req_op == OP_CLR);
    hi_we     = commit_ok | (accept & (req_op == OP_MTHI));
    lo_we     = commit_ok | (accept & (req_op == OP_MTLO));
    hi_wd     = commit_ok ? div_r : req_rs;
    lo_wd     = commit_ok ? div_q : req_rs;
  end
  always_comb begin
    cnt_d   = (state_q == S_WAIT) ? cnt_q + CW'(1) : '0;
    div_a_d = take_div ? {{WIDTH{req_rs[WIDTH-1]}}, req_rs} : div_a_q;
    div_b_d = take_div ? req_rt : div_b_q;
    err_d   = (done_w && div_dz) ? ERR_DZ :
              (done_w && div_do) ? ERR_DO :
              tmo                ? ERR_TO :
              err_clr            ? ERR_NONE : err_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      div_a_q <= '0;
      div_b_q <= '0;
      err_q   <= ERR_NONE;
    end else begin
      cnt_q   <= cnt_d;
      div_a_q <= div_a_d;
      div_b_q <= div_b_d;
      err_q   <= err_d;
    end
  end
  assign div_a    = div_a_q;
  assign div_b    = div_b_q;
  assign err_code = err_q;
`ifdef DIV_ZERO_TRAP_EN
  logic dz_trap_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dz_trap_q <= 1'b0;
    else        dz_trap_q <= done_w & div_dz;
  end
  assign dz_trap = dz_trap_q;
`endif
  hilo_regs #(.WIDTH(WIDTH)) u_regs (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (hl_clr),
    .hi_we_i (hi_we),
    .hi_wd_i (hi_wd),
    .lo_we_i (lo_we),
    .lo_wd_i (lo_wd),
    .hi_o    (hi),
    .lo_o    (lo)
  );
endmodule

// File: tb/tb_hilo_div_ctrl.sv
// tb_hilo_div_ctrl: randomized bench with a behavioural divider and HI/LO reference model.
module tb_hilo_div_ctrl;
  localparam int W = 32;
  localparam int TMO = 40;
  logic clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, err_clr = 1'b0;
  logic div_done = 1'b0, div_dz = 1'b0, div_do = 1'b0;
  logic req_ready, busy, div_start;
  logic [1:0] req_op = 2'b00, err_code;
  logic [W-1:0] req_rs = '0, req_rt = '0, div_q = '0, div_r = '0, hi, lo, div_b;
  logic [2*W-1:0] div_a;
`ifdef DIV_ZERO_TRAP_EN
  logic dz_trap;
`endif
  int n_chk = 0, n_pass = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;
  logic [1:0] m_err = 2'b00;
  always #5 clk = ~clk;
  hilo_div_ctrl #(.WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .busy(busy), .hi(hi), .lo(lo),
    .div_start(div_start), .div_a(div_a), .div_b(div_b), .div_q(div_q), .div_r(div_r),
    .div_dz(div_dz), .div_do(div_do), .div_done(div_done), .err_code(err_code),
    .err_clr(err_clr)
`ifdef DIV_ZERO_TRAP_EN
    , .dz_trap(dz_trap)
`endif
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic check_state(input string tag);
    check({tag, "_hi"}, 64'(hi), 64'(m_hi));
    check({tag, "_lo"}, 64'(lo), 64'(m_lo));
    check({tag, "_err"}, 64'(err_code), 64'(m_err));
  endtask
  task automatic do_mt(input logic [1:0] op, input logic [W-1:0] rs);
    req_valid = 1'b1; req_op = op; req_rs = rs;
    @(negedge clk);
    req_valid = 1'b0;
    if (op == 2'b01) m_hi = rs;
    else if (op == 2'b10) m_lo = rs;
    else if (op == 2'b11) begin m_hi = '0; m_lo = '0; end
    check("mt_busy", 64'(busy), 64'd0);
    check_state("mt");
  endtask
  task automatic start_div(input logic [W-1:0] rs, input logic [W-1:0] rt);
    req_valid = 1'b1; req_op = 2'b00; req_rs = rs; req_rt = rt;
    @(negedge clk);
    req_valid = 1'b0;
    check("issue_start", 64'(div_start), 64'd1);
    check("issue_ready", 64'(req_ready), 64'd0);
    check("div_a", div_a, 64'(longint'(int'(rs))));
    check("div_b", 64'(div_b), 64'(rt));
  endtask
  // behavioural divider: answers after `delay` WAIT cycles; delay > TMO never answers
  task automatic wait_div(input logic [W-1:0] rs, input logic [W-1:0] rt, input int delay, input logic clr);
    int a, b, cyc, exp_cyc;
    logic dz, dov;
    a = int'(rs); b = int'(rt);
    dz = (b == 0);
    dov = !dz && (a == int'(32'h8000_0000)) && (b == -1);
    div_done = 1'b1; div_dz = 1'b1; div_q = 32'h5555_5555; div_r = 32'h5555_5555;
    @(negedge clk);
    div_done = 1'b0; div_dz = 1'b0; err_clr = 1'b0;
    check("wait_no_start", 64'(div_start), 64'd0);
    check_state("wait_entry");
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      div_done = (cyc == delay);
      err_clr = div_done && clr;
      div_dz = dz; div_do = dov;
      div_q = (dz || dov) ? 32'hDEAD_BEEF : 32'(a / b);
      div_r = (dz || dov) ? 32'hDEAD_BEEF : 32'(a % b);
      @(negedge clk);
      div_done = 1'b0; err_clr = 1'b0;
    end
    if (cyc >= 100) check("wait_bound", 64'(busy), 64'd0);
    exp_cyc = (delay <= TMO) ? delay : TMO;
    check("wait_cycles", 64'(cyc), 64'(exp_cyc));
    if (delay <= TMO) begin
      if (dz) m_err = 2'b01;
      else if (dov) m_err = 2'b10;
      else begin
        m_lo = 32'(a / b);
        m_hi = 32'(a % b);
        if (clr) m_err = 2'b00;
      end
    end else m_err = 2'b11;
`ifdef DIV_ZERO_TRAP_EN
    check("dz_trap", 64'(dz_trap), 64'(dz && delay <= TMO));
`endif
    check("done_ready", 64'(req_ready), 64'd1);
    check_state("div");
  endtask
  task automatic late_done();
    div_done = 1'b1; div_q = 32'hCAFE_0001; div_r = 32'hCAFE_0002; div_dz = 1'b0; div_do = 1'b0;
    repeat (2) @(negedge clk);
    div_done = 1'b0;
    check("late_busy", 64'(busy), 64'd0);
    check_state("late");
  endtask
  initial begin
    logic [W-1:0] rs, rt;
    int k;
    repeat (2) @(negedge clk);
    check_state("reset");
    check("reset_ready", 64'(req_ready), 64'd1);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_start", 64'(div_start), 64'd0);
    check("reset_div_a", div_a, 64'd0);
    check("reset_div_b", 64'(div_b), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    do_mt(2'b01, 32'h1234_5678);
    do_mt(2'b10, 32'h9ABC_DEF0);
    start_div(32'hFFFF_FFF9, 32'd2);
    wait_div(32'hFFFF_FFF9, 32'd2, 34, 1'b0);
    start_div(32'd5, 32'd0);
    wait_div(32'd5, 32'd0, 10, 1'b0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0; m_err = 2'b00;
    check_state("err_clr");
    start_div(32'd100, 32'd3);
    wait_div(32'd100, 32'd3, 1000, 1'b0);
    late_done();
    start_div(32'd9, 32'd4);
    err_clr = 1'b1; m_err = 2'b00;
    wait_div(32'd9, 32'd4, TMO, 1'b0);
    start_div(32'h8000_0000, 32'hFFFF_FFFF);
    wait_div(32'h8000_0000, 32'hFFFF_FFFF, 3, 1'b0);
    start_div(32'd20, 32'd6);
    wait_div(32'd20, 32'd6, 2, 1'b1);
    start_div(32'd1, 32'd0);
    wait_div(32'd1, 32'd0, 2, 1'b1);
    start_div(32'd77, 32'd5);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_hi = '0; m_lo = '0; m_err = 2'b00;
    check_state("async_rst");
    check("async_rst_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    start_div(32'd100, 32'd7);
    wait_div(32'd100, 32'd7, 20, 1'b0);
    start_div(32'd50, 32'd7);
    req_valid = 1'b1; req_op = 2'b10; req_rs = 32'd1;
    wait_div(32'd50, 32'd7, 6, 1'b0);
    @(negedge clk);
    req_valid = 1'b0; m_lo = 32'd1;
    check("held_busy", 64'(busy), 64'd0);
    check_state("held");
    for (int i = 0; i < 30; i++) begin
      k = $urandom_range(0, 6);
      rs = $urandom;
      rt = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($signed($urandom_range(0, 2000)) - 1000);
      if ($urandom_range(0, 9) == 0) begin rs = 32'h8000_0000; rt = 32'hFFFF_FFFF; end
      if (k <= 2) begin
        start_div(rs, rt);
        wait_div(rs, rt, $urandom_range(1, TMO + 4), 1'($urandom_range(0, 3) == 0));
      end else if (k == 6) begin
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0; m_err = 2'b00;
        check_state("rand_clr");
      end else do_mt(2'(k - 2), rs);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
